jb_predict_ctrl: RTL and testbench

- Decode-stage branch/jump control unit with dynamic branch prediction.
- Decodes MIPS branch and jump opcodes into a branch-op code, a jump-select code and a link flag.
- Predicts conditional branches from a pattern history table (PHT) of 2-bit saturating counters, trained by the execute stage.
- On a mispredict, runs a parametrised flush/recovery sequence that squashes younger instructions and holds fetch.

---
 rtl/jb_predict_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_jb_predict_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_predict_ctrl.sv
// Decode-stage branch/jump control with a bimodal PHT of 2-bit saturating
// counters and a mispredict flush/recovery FSM.
// Optional feature macro: JB_GSHARE_EN (gshare indexing with a global history register).
module jb_predict_ctrl #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [1:0]  CTR_INIT     = 2'b01,
    localparam int unsigned IDX_W       = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [5:0]       i_instru,
    input  logic [5:0]       i_func,
    input  logic             i_rt,
    input  logic             i_upd_valid,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    input  logic             i_upd_pred,
    output logic [2:0]       o_bop,
    output logic [1:0]       o_jump,
    output logic             o_aluPC4,
    output logic             o_pred_taken,
    output logic [IDX_W-1:0] o_pred_idx,
    output logic             o_ifstall,
    output logic             o_flush
);

    localparam int unsigned   CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       pht [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             mispredict;

    logic [2:0]       dec_bop;
    logic [1:0]       dec_jump;
    logic             dec_link;
    logic             dec_cond;

    // PC bits outside the index field carry no information for prediction
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_pc[PC_W-1:IDX_W+2], i_pc[1:0]};

    assign mispredict = i_upd_valid && (i_upd_taken != i_upd_pred);

`ifdef JB_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Global history: shift in every resolved conditional-branch outcome
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ghr <= '0;
        end else if (i_upd_valid) begin
            ghr <= {ghr[IDX_W-2:0], i_upd_taken};
        end
    end

    assign idx = i_pc[IDX_W+1:2] ^ ghr;
`else
    assign idx = i_pc[IDX_W+1:2];
`endif

    assign o_pred_idx = idx;

    // PHT training: saturating 2-bit counters, written regardless of FSM state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pht[IDX_W'(i)] <= CTR_INIT;
            end
        end else if (i_upd_valid) begin
            if (i_upd_taken) begin
                if (pht[i_upd_idx] != 2'b11) begin
                    pht[i_upd_idx] <= pht[i_upd_idx] + 2'd1;
                end
            end else begin
                if (pht[i_upd_idx] != 2'b00) begin
                    pht[i_upd_idx] <= pht[i_upd_idx] - 2'd1;
                end
            end
        end
    end

    // Opcode decode into branch op, jump select and link flag
    always_comb begin
        dec_bop  = 3'b000;
        dec_jump = 2'b00;
        dec_link = 1'b0;
        dec_cond = 1'b0;
        case (i_instru)
            6'b000100: begin dec_bop = 3'b001; dec_cond = 1'b1; end
            6'b000101: begin dec_bop = 3'b010; dec_cond = 1'b1; end
            6'b000110: begin dec_bop = 3'b011; dec_cond = 1'b1; end
            6'b000111: begin dec_bop = 3'b100; dec_cond = 1'b1; end
            6'b000001: begin
                dec_bop  = i_rt ? 3'b110 : 3'b101;
                dec_cond = 1'b1;
            end
            6'b000010: dec_jump = 2'b01;
            6'b000011: begin dec_jump = 2'b01; dec_link = 1'b1; end
            6'b000000: begin
                if (i_func == 6'b001000) begin
                    dec_jump = 2'b10;
                end
            end
            default:   dec_jump = 2'b11;
        endcase
    end

    // FSM state and flush counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a mispredict (re)arms the flush window from any state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (mispredict) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            S_FLUSH: begin
                if (mispredict) begin
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: flush/stall follow the state register; decode is squashed while flushing
    always_comb begin
        o_bop        = 3'b000;
        o_jump       = 2'b00;
        o_aluPC4     = 1'b0;
        o_pred_taken = 1'b0;
        o_flush      = (state == S_FLUSH);
        o_ifstall    = (state == S_FLUSH);
        if ((state == S_IDLE) && i_valid) begin
            o_bop    = dec_bop;
            o_jump   = dec_jump;
            o_aluPC4 = dec_link;
            if (dec_cond) begin
                o_pred_taken = pht[idx][1];
            end else begin
                o_pred_taken = (dec_jump == 2'b01) || (dec_jump == 2'b10);
            end
        end
    end

endmodule

// File: tb/tb_jb_predict_ctrl.sv
// Scoreboard bench for jb_predict_ctrl against a behavioural predictor model.
module tb_jb_predict_ctrl;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned IDX_W  = 6;
    localparam int          FLUSHN = 2;
    localparam int          CINIT  = 1;

    typedef struct packed {
        logic [2:0]       bop;
        logic [1:0]       jump;
        logic             link;
        logic             pred;
        logic [IDX_W-1:0] idx;
        logic             stall;
        logic             flush;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic [PC_W-1:0]  pc;
    logic [5:0]       instru;
    logic [5:0]       func;
    logic             rt;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_pred;
    logic [2:0]       bop;
    logic [1:0]       jump;
    logic             alupc4;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             ifstall;
    logic             flush;

    jb_predict_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_pc         (pc),
        .i_instru     (instru),
        .i_func       (func),
        .i_rt         (rt),
        .i_upd_valid  (upd_valid),
        .i_upd_idx    (upd_idx),
        .i_upd_taken  (upd_taken),
        .i_upd_pred   (upd_pred),
        .o_bop        (bop),
        .o_jump       (jump),
        .o_aluPC4     (alupc4),
        .o_pred_taken (pred_taken),
        .o_pred_idx   (pred_idx),
        .o_ifstall    (ifstall),
        .o_flush      (flush)
    );

    always #5 clk = ~clk;

    // Reference model state
    int   pht_m [DEPTH];
    int   flush_left;
    int   ghr_m;
    obs_t sb_q [$];
    int   n_chk;
    int   n_fail;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) pht_m[i] = CINIT;
        flush_left = 0;
        ghr_m      = 0;
    endfunction

    function automatic obs_t model_out();
        obs_t e;
        int   op;
        int   ix;
        bit   cond;
        op   = int'(instru);
        ix   = int'(pc[IDX_W+1:2]);
`ifdef JB_GSHARE_EN
        ix   = ix ^ ghr_m;
`endif
        e    = '0;
        cond = 1'b0;
        e.idx   = IDX_W'(ix);
        e.flush = (flush_left > 0);
        e.stall = (flush_left > 0);
        if (op >= 4 && op <= 7) begin
            e.bop = 3'(op - 3);
            cond  = 1'b1;
        end else if (op == 1) begin
            e.bop = rt ? 3'd6 : 3'd5;
            cond  = 1'b1;
        end else if (op == 2 || op == 3) begin
            e.jump = 2'd1;
            e.link = (op == 3);
            e.pred = 1'b1;
        end else if (op == 0) begin
            if (func == 6'd8) begin
                e.jump = 2'd2;
                e.pred = 1'b1;
            end
        end else begin
            e.jump = 2'd3;
        end
        if (cond) e.pred = (pht_m[ix] >= 2);
        if (flush_left > 0 || !valid) begin
            e.bop  = '0;
            e.jump = '0;
            e.link = 1'b0;
            e.pred = 1'b0;
        end
        return e;
    endfunction

    function automatic void model_edge();
        int c;
        if (flush_left > 0) flush_left--;
        if (upd_valid) begin
            c = pht_m[int'(upd_idx)];
            if (upd_taken) c = (c < 3) ? c + 1 : 3;
            else           c = (c > 0) ? c - 1 : 0;
            pht_m[int'(upd_idx)] = c;
            ghr_m = ((ghr_m << 1) | int'(upd_taken)) & (DEPTH - 1);
            if (upd_taken != upd_pred) flush_left = FLUSHN;
        end
    endfunction

    // Applies one cycle of stimulus (called at posedge+1) and queues the expected observation
    task automatic drive(input logic v, input logic [31:0] p, input logic [5:0] op,
                         input logic [5:0] fn, input logic r, input logic uv,
                         input logic [5:0] ui, input logic ut, input logic up);
        valid = v; pc = p; instru = op; func = fn; rt = r;
        upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
        #0;
        sb_q.push_back(model_out());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic direct_chk(input string name, input logic got, input logic want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g = {bop, jump, alupc4, pred_taken, pred_idx, ifstall, flush};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got bop=%b jump=%b link=%b pred=%b idx=%h stall=%b flush=%b expected bop=%b jump=%b link=%b pred=%b idx=%h stall=%b flush=%b",
                         $time, g.bop, g.jump, g.link, g.pred, g.idx, g.stall, g.flush,
                         e.bop, e.jump, e.link, e.pred, e.idx, e.stall, e.flush);
            end
        end
    end

    logic [5:0] op_tbl [11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'h3f, 6'h08, 6'h23};

    initial begin
        n_chk = 0;
        n_fail = 0;
        model_reset();
        rst = 1'b1; valid = 1'b0; pc = '0; instru = '0; func = '0; rt = 1'b0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_pred = 1'b0;
        #2;
        direct_chk("reset_flush", flush, 1'b0);
        direct_chk("reset_ifstall", ifstall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // beq from reset state
        drive(1, 32'h100, 6'b000100, 0, 0, 0, 0, 0, 0);

        // saturation up and back down on index 5
        repeat (3) drive(0, 0, 0, 0, 0, 1, 6'd5, 1, 1);
        drive(1, 32'h014, 6'b000100, 0, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 1, 6'd5, 0, 0);
        drive(1, 32'h014, 6'b000101, 0, 0, 0, 0, 0, 0);

        // decode coverage
        drive(1, 32'h020, 6'b000001, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h024, 6'b000001, 0, 1, 0, 0, 0, 0);
        drive(1, 32'h028, 6'b000011, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h02c, 6'b000000, 6'b001000, 0, 0, 0, 0, 0);
        drive(1, 32'h030, 6'b000000, 6'b100000, 0, 0, 0, 0, 0);
        drive(1, 32'h034, 6'b111111, 0, 0, 0, 0, 0, 0);
        drive(0, 32'h038, 6'b000011, 0, 0, 0, 0, 0, 0);

        // single mispredict, then extended flush by a second mispredict
        drive(1, 32'h040, 6'b000100, 0, 0, 1, 6'd9, 1, 0);
        repeat (3) drive(1, 32'h044, 6'b000011, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h048, 6'b000100, 0, 0, 1, 6'd10, 1, 0);
        drive(1, 32'h04c, 6'b000010, 0, 0, 1, 6'd10, 0, 1);
        repeat (4) drive(1, 32'h050, 6'b000010, 0, 0, 0, 0, 0, 0);

        // reset in the middle of a flush
        drive(1, 32'h060, 6'b000100, 0, 0, 1, 6'd11, 0, 1);
        drive(1, 32'h064, 6'b000010, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        direct_chk("midflush_rst_flush", flush, 1'b0);
        direct_chk("midflush_rst_ifstall", ifstall, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // every entry reinitialised: one taken step from the init value then read back
        for (int i = 0; i < DEPTH; i++)
            drive(1, 32'(i) << 2, 6'b000100, 0, 0, 1, 6'(i), 1, 1);
        for (int i = 0; i < DEPTH; i++)
            drive(1, 32'(i) << 2, 6'b000111, 0, 0, 0, 0, 0, 0);

        // randomized traffic concentrated on a few indices to exercise saturation
        for (int n = 0; n < 2000; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            logic       t;
            logic       pr;
            op = op_tbl[$urandom_range(10, 0)];
            fn = ($urandom_range(1, 0) == 1) ? 6'b001000 : 6'(($urandom_range(63, 0)));
            t  = 1'($urandom_range(1, 0));
            pr = ($urandom_range(7, 0) == 0) ? ~t : t;
            drive(1'($urandom_range(3, 0) != 0), ($urandom & 32'hffff_ffe3) | 32'h0, op, fn,
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  6'($urandom_range(7, 0)), t, pr);
        end

        valid = 1'b0; upd_valid = 1'b0;
        for (int w = 0; w < 8 && sb_q.size() > 0; w++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
